// File: rtl/imm_gen_pipe.sv
// Two-stage RV32/RV64 immediate generator with valid/ready on both sides.
// Stage 1 latches the word plus its decoded format; stage 2 assembles, extends and holds the result.
module imm_gen_pipe #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  input  logic             clr_count,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [2:0] FMT_I     = 3'd0;
  localparam logic [2:0] FMT_S     = 3'd1;
  localparam logic [2:0] FMT_SB    = 3'd2;
  localparam logic [2:0] FMT_U     = 3'd3;
  localparam logic [2:0] FMT_UJ    = 3'd4;
  localparam logic [2:0] FMT_SHAMT = 3'd5;
  localparam logic [2:0] FMT_NONE  = 3'd7;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic             s1_valid_reg;
  logic [31:0]      s1_instr_reg;
  logic [TAG_W-1:0] s1_tag_reg;
  logic [2:0]       s1_fmt_reg;

  logic             out_valid_reg;
  logic [XLEN-1:0]  out_imm_reg;
  logic [2:0]       out_fmt_reg;
  logic             out_illegal_reg;
  logic [TAG_W-1:0] out_tag_reg;
  logic [CNT_W-1:0] count_reg;

  logic             s2_load;
  logic [2:0]       fmt_next;
  logic [31:0]      imm32_next;
  logic [XLEN-1:0]  imm_next;
  logic             count_inc;

  assign s2_load  = !out_valid_reg || out_ready;
  assign in_ready = !s1_valid_reg || s2_load;

  // Format decode happens before stage 1 so stage 2 only has to mux bit fields.
  always_comb begin
    fmt_next = FMT_NONE;
    case (in_instr[6:0])
      OP_IMM, OP_IMM_32: begin
        if (in_instr[14:12] == 3'b001 || in_instr[14:12] == 3'b101) begin
          fmt_next = FMT_SHAMT;
        end else begin
          fmt_next = FMT_I;
        end
      end
      OP_LOAD, OP_JALR, OP_SYSTEM: fmt_next = FMT_I;
      OP_STORE:                    fmt_next = FMT_S;
      OP_BRANCH:                   fmt_next = FMT_SB;
      OP_LUI, OP_AUIPC:            fmt_next = FMT_U;
      OP_JAL:                      fmt_next = FMT_UJ;
      default:                     fmt_next = FMT_NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
    end else if (in_ready) begin
      s1_valid_reg <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      s1_instr_reg <= in_instr;
      s1_tag_reg   <= in_tag;
      s1_fmt_reg   <= fmt_next;
    end
  end

  // Every immediate fits in 32 bits already sign-extended; SHAMT has a zero top bit.
  always_comb begin
    imm32_next = '0;
    case (s1_fmt_reg)
      FMT_I:  imm32_next = {{20{s1_instr_reg[31]}}, s1_instr_reg[31:20]};
      FMT_S:  imm32_next = {{20{s1_instr_reg[31]}}, s1_instr_reg[31:25], s1_instr_reg[11:7]};
      FMT_SB: imm32_next = {{19{s1_instr_reg[31]}}, s1_instr_reg[31], s1_instr_reg[7],
                            s1_instr_reg[30:25], s1_instr_reg[11:8], 1'b0};
      FMT_U:  imm32_next = {s1_instr_reg[31:12], 12'b0};
      FMT_UJ: imm32_next = {{11{s1_instr_reg[31]}}, s1_instr_reg[31], s1_instr_reg[19:12],
                            s1_instr_reg[20], s1_instr_reg[30:21], 1'b0};
      FMT_SHAMT: begin
        // instr[3] separates OP-IMM-32 (word shifts, 5-bit amount) from OP-IMM
        if (XLEN == 64 && !s1_instr_reg[3]) begin
          imm32_next = {26'b0, s1_instr_reg[25:20]};
        end else begin
          imm32_next = {27'b0, s1_instr_reg[24:20]};
        end
      end
      default: imm32_next = '0;
    endcase
  end

  generate
    if (XLEN > 32) begin : g_wide
      assign imm_next = {{(XLEN-32){imm32_next[31]}}, imm32_next};
    end else begin : g_narrow
      assign imm_next = imm32_next[XLEN-1:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg   <= 1'b0;
      out_imm_reg     <= '0;
      out_fmt_reg     <= FMT_NONE;
      out_illegal_reg <= 1'b0;
      out_tag_reg     <= '0;
    end else if (s2_load) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_imm_reg     <= imm_next;
        out_fmt_reg     <= s1_fmt_reg;
        out_illegal_reg <= (s1_fmt_reg == FMT_NONE);
        out_tag_reg     <= s1_tag_reg;
      end
    end
  end

  assign count_inc = out_valid_reg && out_ready && out_illegal_reg;

  always_ff @(posedge clk) begin
    if (reset || clr_count) begin
      count_reg <= '0;
    end else if (count_inc && count_reg != '1) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign out_valid     = out_valid_reg;
  assign out_imm       = out_imm_reg;
  assign out_fmt       = out_fmt_reg;
  assign out_illegal   = out_illegal_reg;
  assign out_tag       = out_tag_reg;
  assign illegal_count = count_reg;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: an RV64 instance (16-bit counter) and an RV32 instance
// (4-bit counter so saturation is reachable quickly).
module tb_imm_gen_pipe;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [7:0]  tag;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_illegal, a_clr;
  logic [31:0] a_instr;
  logic [7:0]  a_tag, a_out_tag;
  logic [63:0] a_out_imm;
  logic [2:0]  a_out_fmt;
  logic [15:0] a_cnt;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_illegal, b_clr;
  logic [31:0] b_instr;
  logic [7:0]  b_tag, b_out_tag;
  logic [31:0] b_out_imm;
  logic [2:0]  b_out_fmt;
  logic [3:0]  b_cnt;

  imm_gen_pipe #(.XLEN(64), .TAG_W(8), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_instr(a_instr), .in_tag(a_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_imm(a_out_imm), .out_fmt(a_out_fmt),
    .out_illegal(a_out_illegal), .out_tag(a_out_tag),
    .clr_count(a_clr), .illegal_count(a_cnt)
  );

  imm_gen_pipe #(.XLEN(32), .TAG_W(8), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_instr), .in_tag(b_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_imm(b_out_imm), .out_fmt(b_out_fmt),
    .out_illegal(b_out_illegal), .out_tag(b_out_tag),
    .clr_count(b_clr), .illegal_count(b_cnt)
  );

  int   n_total = 0;
  int   n_bad = 0;
  bit   chk_en = 1'b0;
  bit   a_rnd = 1'b0;
  int   a_acc = 0;
  exp_t a_q[$];
  exp_t b_q[$];
  exp_t a_e, b_e;
  logic [15:0] a_exp_cnt = '0;
  logic [3:0]  b_exp_cnt = '0;
  logic        a_hold = 1'b0;
  logic [63:0] a_hold_imm;
  logic [7:0]  a_hold_tag;
  logic [2:0]  a_hold_fmt;
  logic [6:0]  ops [12];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] imm, input logic [2:0] fmt,
                              input logic ill, input logic [7:0] tag);
    exp_t e;
    e.imm = imm; e.fmt = fmt; e.ill = ill; e.tag = tag;
    return e;
  endfunction

  // Reference decoder written straight from the instruction-format tables.
  function automatic exp_t model(input logic [31:0] w, input logic [7:0] tag, input int xlen);
    exp_t e;
    logic [6:0] op;
    logic [2:0] f3;
    op = w[6:0];
    f3 = w[14:12];
    e.tag = tag; e.ill = 1'b0; e.imm = '0; e.fmt = 3'd7;
    if ((op == 7'h13 || op == 7'h1B) && (f3 == 3'd1 || f3 == 3'd5)) begin
      e.fmt = 3'd5;
      if (op == 7'h13 && xlen == 64) e.imm = {58'b0, w[25:20]};
      else e.imm = {59'b0, w[24:20]};
    end else if (op == 7'h13 || op == 7'h1B || op == 7'h03 || op == 7'h67 || op == 7'h73) begin
      e.fmt = 3'd0; e.imm = {{52{w[31]}}, w[31:20]};
    end else if (op == 7'h23) begin
      e.fmt = 3'd1; e.imm = {{52{w[31]}}, w[31:25], w[11:7]};
    end else if (op == 7'h63) begin
      e.fmt = 3'd2; e.imm = {{51{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    end else if (op == 7'h37 || op == 7'h17) begin
      e.fmt = 3'd3; e.imm = {{32{w[31]}}, w[31:12], 12'b0};
    end else if (op == 7'h6F) begin
      e.fmt = 3'd4; e.imm = {{43{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    end else begin
      e.ill = 1'b1;
    end
    if (xlen == 32) e.imm = {32'b0, e.imm[31:0]};
    return e;
  endfunction

  task automatic send_a(input exp_t e, input logic [31:0] w);
    int n = 0;
    a_in_valid = 1'b1; a_instr = w; a_tag = e.tag;
    @(negedge clk);
    while (!a_in_ready && n < 50) begin @(negedge clk); n++; end
    if (!a_in_ready) check_eq("a_accept_timeout", a_in_ready, 1);
    else begin a_q.push_back(e); a_acc++; end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input exp_t e, input logic [31:0] w);
    int n = 0;
    b_in_valid = 1'b1; b_instr = w; b_tag = e.tag;
    @(negedge clk);
    while (!b_in_ready && n < 50) begin @(negedge clk); n++; end
    if (!b_in_ready) check_eq("b_accept_timeout", b_in_ready, 1);
    else b_q.push_back(e);
    @(posedge clk); #1;
    b_in_valid = 1'b0;
  endtask

  task automatic drain_a();
    int n = 0;
    while (a_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
    if (a_q.size() != 0) check_eq("a_drain_timeout", 64'(a_q.size()), 0);
    @(posedge clk); #1;
  endtask

  task automatic drain_b();
    int n = 0;
    while (b_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
    if (b_q.size() != 0) check_eq("b_drain_timeout", 64'(b_q.size()), 0);
    @(posedge clk); #1;
  endtask

  always @(posedge clk) begin
    #1;
    if (a_rnd) a_out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor A: pops the scoreboard, tracks the counter, checks hold-stability under stall.
  always @(negedge clk) begin
    if (reset) begin
      a_q.delete();
      a_exp_cnt = '0;
      a_hold = 1'b0;
    end else if (chk_en) begin
      check_eq("a_count", a_cnt, a_exp_cnt);
      if (a_hold) begin
        check_eq("a_hold_valid", a_out_valid, 1);
        check_eq("a_hold_imm", a_out_imm, a_hold_imm);
        check_eq("a_hold_tag", a_out_tag, a_hold_tag);
        check_eq("a_hold_fmt", a_out_fmt, a_hold_fmt);
      end
      if (a_out_valid && a_out_ready) begin
        if (a_q.size() == 0) check_eq("a_unexpected_result", 64'(a_q.size()), 1);
        else begin
          a_e = a_q.pop_front();
          $display("a result tag=%0h imm=%0h fmt=%0d ill=%0b", a_out_tag, a_out_imm, a_out_fmt, a_out_illegal);
          check_eq("a_imm", a_out_imm, a_e.imm);
          check_eq("a_fmt", a_out_fmt, a_e.fmt);
          check_eq("a_illegal", a_out_illegal, a_e.ill);
          check_eq("a_tag", a_out_tag, a_e.tag);
          if (a_e.ill && a_exp_cnt != 16'hFFFF) a_exp_cnt = a_exp_cnt + 16'd1;
        end
      end
      if (a_clr) a_exp_cnt = '0;
      a_hold = a_out_valid && !a_out_ready;
      a_hold_imm = a_out_imm; a_hold_tag = a_out_tag; a_hold_fmt = a_out_fmt;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      b_q.delete();
      b_exp_cnt = '0;
    end else if (chk_en) begin
      check_eq("b_count", b_cnt, b_exp_cnt);
      if (b_out_valid && b_out_ready) begin
        if (b_q.size() == 0) check_eq("b_unexpected_result", 64'(b_q.size()), 1);
        else begin
          b_e = b_q.pop_front();
          $display("b result tag=%0h imm=%0h fmt=%0d ill=%0b", b_out_tag, b_out_imm, b_out_fmt, b_out_illegal);
          check_eq("b_imm", {32'b0, b_out_imm}, b_e.imm);
          check_eq("b_fmt", b_out_fmt, b_e.fmt);
          check_eq("b_illegal", b_out_illegal, b_e.ill);
          check_eq("b_tag", b_out_tag, b_e.tag);
          if (b_e.ill && b_exp_cnt != 4'hF) b_exp_cnt = b_exp_cnt + 4'd1;
        end
      end
    end
  end

  initial begin
    logic [31:0] w;
    int base;
    ops = '{7'h13, 7'h1B, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h00};
    a_in_valid = 0; a_instr = 0; a_tag = 0; a_out_ready = 1; a_clr = 0;
    b_in_valid = 0; b_instr = 0; b_tag = 0; b_out_ready = 1; b_clr = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_out_valid", a_out_valid, 0);
    check_eq("rst_out_fmt", a_out_fmt, 7);
    check_eq("rst_out_imm", a_out_imm, 0);
    check_eq("rst_out_illegal", a_out_illegal, 0);
    check_eq("rst_out_tag", a_out_tag, 0);
    check_eq("rst_count", a_cnt, 0);
    check_eq("rst_in_ready", a_in_ready, 1);
    check_eq("rst_b_out_valid", b_out_valid, 0);
    check_eq("rst_b_out_fmt", b_out_fmt, 7);
    chk_en = 1'b1;
    @(posedge clk); #1;

    // Reference vectors, including first-result latency.
    send_a(mk(64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 1'b0, 8'h01), 32'hFFF00093);
    @(negedge clk); check_eq("lat_not_early", a_out_valid, 0);
    @(negedge clk); check_eq("lat_two_cycles", a_out_valid, 1);
    @(posedge clk); #1;
    send_a(mk(64'hFFFF_FFFF_FFFF_FFF8, 3'd1, 1'b0, 8'h02), 32'hFE113C23);
    send_a(mk(64'hFFFF_FFFF_8000_0000, 3'd3, 1'b0, 8'h03), 32'h800002B7);
    send_a(mk(64'hFFFF_FFFF_FFFF_FFFC, 3'd4, 1'b0, 8'h04), 32'hFFDFF06F);
    send_a(mk(64'h3F, 3'd5, 1'b0, 8'h05), 32'h43F0D093);
    send_a(mk(64'h1F, 3'd5, 1'b0, 8'h06), 32'h43F0D09B);
    drain_a();
    send_b(mk(64'h1F, 3'd5, 1'b0, 8'h11), 32'h43F0D093);
    send_b(mk(64'h0000_0000_FFFF_FFFF, 3'd0, 1'b0, 8'h12), 32'hFFF00093);
    send_b(mk(64'h0000_0000_8000_0000, 3'd3, 1'b0, 8'h13), 32'h800002B7);
    drain_b();

    // Illegal word and counter behaviour.
    send_a(mk(64'h0, 3'd7, 1'b1, 8'h20), 32'h0000_0000);
    drain_a();
    check_eq("cnt_after_illegal", a_cnt, 1);
    a_clr = 1'b1;
    send_a(mk(64'h0, 3'd7, 1'b1, 8'h21), 32'h0000_0000);
    drain_a();
    check_eq("cnt_clr_wins", a_cnt, 0);
    a_clr = 1'b0;
    for (int i = 0; i < 20; i++) send_b(mk(64'h0, 3'd7, 1'b1, 8'(8'h30 + i)), 32'h0000_007F);
    drain_b();
    check_eq("cnt_saturated", b_cnt, 4'hF);

    // Random mix with random backpressure.
    a_rnd = 1'b1;
    for (int i = 0; i < 40; i++) begin
      w = $urandom;
      w[6:0] = ops[$urandom_range(0, 11)];
      send_a(model(w, 8'(8'h80 + i), 64), w);
    end
    drain_a();
    a_rnd = 1'b0;
    a_out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      w = $urandom;
      w[6:0] = ops[$urandom_range(0, 11)];
      send_b(model(w, 8'(8'hC0 + i), 32), w);
    end
    drain_b();

    // Stream 5 with the consumer stalled for 3 cycles.
    a_out_ready = 1'b0;
    base = a_acc;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          w = 32'h0000_0013 | (32'(i) << 20);
          send_a(mk(64'(i), 3'd0, 1'b0, 8'(8'h50 + i)), w);
        end
      end
      begin
        repeat (3) @(negedge clk);
        #1;
        check_eq("stall_in_ready", a_in_ready, 0);
        check_eq("stall_accepted", 64'(a_acc - base), 2);
        @(posedge clk); #1;
        a_out_ready = 1'b1;
      end
    join
    drain_a();

    // Reset with both stages full and stalled.
    a_out_ready = 1'b0;
    send_a(mk(64'h0, 3'd7, 1'b1, 8'hE0), 32'h0000_0000);
    send_a(mk(64'h0, 3'd7, 1'b1, 8'hE1), 32'h0000_0000);
    @(negedge clk);
    check_eq("full_in_ready", a_in_ready, 0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst2_out_valid", a_out_valid, 0);
    check_eq("rst2_in_ready", a_in_ready, 1);
    check_eq("rst2_count", a_cnt, 0);
    a_out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("rst2_no_leftover", a_out_valid, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
